// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = REG_W'(0);

  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } miss_state_e;

  // Hold/clear controls for the F..W segment registers
  typedef struct packed {
    logic bubble_f;
    logic bubble_d;
    logic bubble_e;
    logic bubble_m;
    logic bubble_w;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } seg_ctl_t;

  // A load in EX produces a register that the instruction in ID consumes
  function automatic logic load_use_hit(
    input logic             wb_select_ex,
    input logic             reg_write_en_ex,
    input logic [REG_W-1:0] rd_ex,
    input logic [REG_W-1:0] rs1_id,
    input logic             rs1_use_id,
    input logic [REG_W-1:0] rs2_id,
    input logic             rs2_use_id
  );
    logic src_match;
    src_match = (rs1_use_id && (rs1_id == rd_ex)) ||
                (rs2_use_id && (rs2_id == rd_ex));
    return wb_select_ex && reg_write_en_ex && (rd_ex != REG_X0) && src_match;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard sources from ID/EX/MEM and the segment-register controls and statistics returned.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  import hazard_ctrl_pkg::*;

  logic [REG_W-1:0] rs1_ID;
  logic [REG_W-1:0] rs2_ID;
  logic             rs1_use_ID;
  logic             rs2_use_ID;
  logic [REG_W-1:0] rd_EX;
  logic             wb_select_EX;
  logic             reg_write_en_EX;
  logic             br_EX;
  logic             jalr_EX;
  logic             jal_ID;
  logic             miss_MEM;
  logic             mem_ready;

  logic             bubbleF;
  logic             bubbleD;
  logic             bubbleE;
  logic             bubbleM;
  logic             bubbleW;
  logic             flushD;
  logic             flushE;
  logic             flushM;
  logic             flushW;
  logic             miss_timeout_err;
  logic [CNT_W-1:0] cnt_stall;
  logic [CNT_W-1:0] cnt_ctrl_flush;
  logic [CNT_W-1:0] cnt_load_use;

  // Pipeline side: raises hazard sources, consumes controls
  modport master (
    output rs1_ID, rs2_ID, rs1_use_ID, rs2_use_ID, rd_EX, wb_select_EX,
           reg_write_en_EX, br_EX, jalr_EX, jal_ID, miss_MEM, mem_ready,
    input  bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
           flushD, flushE, flushM, flushW,
           miss_timeout_err, cnt_stall, cnt_ctrl_flush, cnt_load_use
  );

  // Controller side
  modport slave (
    input  rs1_ID, rs2_ID, rs1_use_ID, rs2_use_ID, rd_EX, wb_select_EX,
           reg_write_en_EX, br_EX, jalr_EX, jal_ID, miss_MEM, mem_ready,
    output bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
           flushD, flushE, flushM, flushW,
           miss_timeout_err, cnt_stall, cnt_ctrl_flush, cnt_load_use
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous reset.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: miss-stall FSM with watchdog, control/load-use priority
// resolution driving bubble/flush of every segment register, and saturating statistics.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MISS_TIMEOUT = 256,
  parameter int unsigned CNT_W        = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned TO_W = (MISS_TIMEOUT > 2) ? $clog2(MISS_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MISS_TIMEOUT - 1);

  miss_state_e     state;
  miss_state_e     state_nx;
  logic            stall;
  logic [TO_W-1:0] tmo_cnt;
  logic [TO_W-1:0] tmo_cnt_nx;
  logic            err_set;
  logic            err;
  logic            load_use;
  seg_ctl_t        ctl;
  logic            inc_stall;
  logic            inc_ctrl;
  logic            inc_lu;

  // Miss FSM state and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= tmo_cnt_nx;
    end
  end

  // A hit-under-ready in RUN never enters MISS; the counter holds at its last value
  always_comb begin
    state_nx   = state;
    stall      = 1'b0;
    tmo_cnt_nx = tmo_cnt;
    err_set    = 1'b0;
    unique case (state)
      RUN: begin
        if (hz.miss_MEM && !hz.mem_ready) begin
          state_nx = MISS;
          stall    = 1'b1;
        end
      end
      MISS: begin
        if (hz.mem_ready) begin
          state_nx   = RUN;
          tmo_cnt_nx = '0;
        end else begin
          stall = 1'b1;
          if (tmo_cnt != TO_LAST) begin
            tmo_cnt_nx = tmo_cnt + TO_W'(1);
          end
          err_set = (tmo_cnt_nx == TO_LAST);
        end
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  // Sticky watchdog flag; stalling is not affected by it
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

  assign load_use = load_use_hit(hz.wb_select_EX, hz.reg_write_en_EX, hz.rd_EX,
                                 hz.rs1_ID, hz.rs1_use_ID, hz.rs2_ID, hz.rs2_use_ID);

  // Exactly one rule wins per cycle; deferred hazards re-present once the stall lifts
  always_comb begin
    ctl       = '0;
    inc_stall = 1'b0;
    inc_ctrl  = 1'b0;
    inc_lu    = 1'b0;
    if (rst) begin
      ctl.flush_d = 1'b1;
      ctl.flush_e = 1'b1;
      ctl.flush_m = 1'b1;
      ctl.flush_w = 1'b1;
    end else if (stall) begin
      ctl.bubble_f = 1'b1;
      ctl.bubble_d = 1'b1;
      ctl.bubble_e = 1'b1;
      ctl.bubble_m = 1'b1;
      ctl.bubble_w = 1'b1;
      inc_stall    = 1'b1;
    end else if (hz.br_EX || hz.jalr_EX) begin
      ctl.flush_d = 1'b1;
      ctl.flush_e = 1'b1;
      inc_ctrl    = 1'b1;
    end else if (load_use) begin
      ctl.bubble_f = 1'b1;
      ctl.bubble_d = 1'b1;
      ctl.flush_e  = 1'b1;
      inc_lu       = 1'b1;
    end else if (hz.jal_ID) begin
      ctl.flush_d = 1'b1;
      inc_ctrl    = 1'b1;
    end
  end

  assign hz.bubbleF          = ctl.bubble_f;
  assign hz.bubbleD          = ctl.bubble_d;
  assign hz.bubbleE          = ctl.bubble_e;
  assign hz.bubbleM          = ctl.bubble_m;
  assign hz.bubbleW          = ctl.bubble_w;
  assign hz.flushD           = ctl.flush_d;
  assign hz.flushE           = ctl.flush_e;
  assign hz.flushM           = ctl.flush_m;
  assign hz.flushW           = ctl.flush_w;
  assign hz.miss_timeout_err = err;

  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_stall),
    .count (hz.cnt_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_ctrl_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_ctrl),
    .count (hz.cnt_ctrl_flush)
  );

  sat_counter #(.W(CNT_W)) u_cnt_load_use (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_lu),
    .count (hz.cnt_load_use)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short miss timeout so the watchdog is reachable.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MISS_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // {bF,bD,bE,bM,bW,fD,fE,fM,fW}
  logic [8:0] ctl;
  assign ctl = {hz.bubbleF, hz.bubbleD, hz.bubbleE, hz.bubbleM, hz.bubbleW,
                hz.flushD, hz.flushE, hz.flushM, hz.flushW};

  localparam logic [8:0] C_NONE  = 9'b00000_0000;
  localparam logic [8:0] C_RST   = 9'b00000_1111;
  localparam logic [8:0] C_STALL = 9'b11111_0000;
  localparam logic [8:0] C_BR    = 9'b00000_1100;
  localparam logic [8:0] C_LU    = 9'b11000_0100;
  localparam logic [8:0] C_JAL   = 9'b00000_1000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.rs1_ID          = '0;
    hz.rs2_ID          = '0;
    hz.rs1_use_ID      = 1'b0;
    hz.rs2_use_ID      = 1'b0;
    hz.rd_EX           = '0;
    hz.wb_select_EX    = 1'b0;
    hz.reg_write_en_EX = 1'b0;
    hz.br_EX           = 1'b0;
    hz.jalr_EX         = 1'b0;
    hz.jal_ID          = 1'b0;
    hz.miss_MEM        = 1'b0;
    hz.mem_ready       = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic use1,
                          input logic [4:0] rs2, input logic use2, input logic wb);
    hz.rd_EX           = rd;
    hz.rs1_ID          = rs1;
    hz.rs1_use_ID      = use1;
    hz.rs2_ID          = rs2;
    hz.rs2_use_ID      = use2;
    hz.wb_select_EX    = wb;
    hz.reg_write_en_EX = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    clear_inputs();

    // Reset held for two cycles
    next_cycle();
    next_cycle();
    check("rst_ctl", 32'(ctl), 32'(C_RST));
    check("rst_cnt_stall", hz.cnt_stall, 0);
    check("rst_cnt_ctrl", hz.cnt_ctrl_flush, 0);
    check("rst_cnt_lu", hz.cnt_load_use, 0);
    check("rst_err", 32'(hz.miss_timeout_err), 0);
    hz.miss_MEM = 1'b1;
    hz.br_EX    = 1'b1;
    #1 check("rst_over_hazards", 32'(ctl), 32'(C_RST));
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    #1 check("post_rst_ctl", 32'(ctl), 32'(C_NONE));
    next_cycle();
    check("post_rst_cnt", hz.cnt_stall + hz.cnt_ctrl_flush + hz.cnt_load_use, 0);

    // Load-use detection
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
    #1 check("lu_rs1", 32'(ctl), 32'(C_LU));
    next_cycle();
    clear_inputs();
    #1 check("lu_cnt1", hz.cnt_load_use, 1);
    check("lu_clear_ctl", 32'(ctl), 32'(C_NONE));
    set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
    #1 check("lu_x0", 32'(ctl), 32'(C_NONE));
    next_cycle();
    set_load(5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1);
    #1 check("lu_rs2", 32'(ctl), 32'(C_LU));
    next_cycle();
    set_load(5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 1'b1);
    #1 check("lu_no_use", 32'(ctl), 32'(C_NONE));
    set_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
    #1 check("lu_not_load", 32'(ctl), 32'(C_NONE));
    next_cycle();
    clear_inputs();
    #1 check("lu_cnt2", hz.cnt_load_use, 2);

    // Control transfers and their priority over load-use / jal
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
    hz.br_EX = 1'b1;
    #1 check("br_over_lu", 32'(ctl), 32'(C_BR));
    next_cycle();
    clear_inputs();
    #1 check("br_cnt_ctrl", hz.cnt_ctrl_flush, 1);
    check("br_cnt_lu", hz.cnt_load_use, 2);
    hz.jalr_EX = 1'b1;
    hz.jal_ID  = 1'b1;
    #1 check("jalr_over_jal", 32'(ctl), 32'(C_BR));
    next_cycle();
    clear_inputs();
    hz.jal_ID = 1'b1;
    #1 check("jal_only", 32'(ctl), 32'(C_JAL));
    next_cycle();
    set_load(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    #1 check("lu_over_jal", 32'(ctl), 32'(C_LU));
    next_cycle();
    clear_inputs();
    #1 check("ctrl_cnt3", hz.cnt_ctrl_flush, 3);
    check("lu_cnt3", hz.cnt_load_use, 3);

    // Ten-cycle miss; the short timeout fires during it without affecting the stall
    hz.miss_MEM = 1'b1;
    hz.jal_ID   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 check($sformatf("miss_stall_%0d", i), 32'(ctl), 32'(C_STALL));
      check($sformatf("miss_err_%0d", i), 32'(hz.miss_timeout_err), 32'(i >= 8));
      next_cycle();
    end
    hz.mem_ready = 1'b1;
    hz.jal_ID    = 1'b0;
    #1 check("miss_ready_ctl", 32'(ctl), 32'(C_NONE));
    next_cycle();
    clear_inputs();
    #1 check("miss_back_run", 32'(ctl), 32'(C_NONE));
    check("miss_cnt_stall", hz.cnt_stall, 10);
    check("miss_cnt_ctrl", hz.cnt_ctrl_flush, 3);
    check("miss_err_sticky", 32'(hz.miss_timeout_err), 1);
    hz.miss_MEM  = 1'b1;
    hz.mem_ready = 1'b1;
    #1 check("hit_ready_same", 32'(ctl), 32'(C_NONE));
    next_cycle();
    clear_inputs();
    #1 check("hit_stays_run", 32'(ctl), 32'(C_NONE));
    check("hit_cnt_stall", hz.cnt_stall, 10);

    rst = 1'b1;
    next_cycle();
    check("rst2_err", 32'(hz.miss_timeout_err), 0);
    check("rst2_cnt_stall", hz.cnt_stall, 0);
    rst = 1'b0;

    // Miss that never returns: error after eight stall cycles, reset clears all
    hz.miss_MEM = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) hz.miss_MEM = 1'b0;
      #1 check($sformatf("tmo_stall_%0d", i), 32'(ctl), 32'(C_STALL));
      check($sformatf("tmo_err_%0d", i), 32'(hz.miss_timeout_err), 32'(i >= 8));
      next_cycle();
    end
    rst = 1'b1;
    #1 check("tmo_rst_ctl", 32'(ctl), 32'(C_RST));
    next_cycle();
    check("tmo_rst_err", 32'(hz.miss_timeout_err), 0);
    rst = 1'b0;
    #1 check("tmo_rst_run", 32'(ctl), 32'(C_NONE));

    // Branch held in EX during a miss is honoured only once the stall lifts
    hz.miss_MEM = 1'b1;
    hz.br_EX    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("br_miss_%0d", i), 32'(ctl), 32'(C_STALL));
      next_cycle();
    end
    hz.mem_ready = 1'b1;
    hz.br_EX     = 1'b0;
    #1 check("br_miss_ready", 32'(ctl), 32'(C_NONE));
    next_cycle();
    clear_inputs();
    hz.br_EX = 1'b1;
    #1 check("br_after_miss", 32'(ctl), 32'(C_BR));
    next_cycle();
    clear_inputs();
    #1 check("br_miss_cnt_ctrl", hz.cnt_ctrl_flush, 1);
    check("br_miss_cnt_stall", hz.cnt_stall, 4);

    // Timeout count restarts per miss: 3 + 5 stalled MISS cycles must not trip it
    hz.miss_MEM = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) hz.miss_MEM = 1'b0;
      next_cycle();
    end
    hz.mem_ready = 1'b1;
    next_cycle();
    clear_inputs();
    #1 check("tmo_restart_err", 32'(hz.miss_timeout_err), 0);
    check("tmo_restart_cnt", hz.cnt_stall, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
